// File: rtl/ksw_profile_seq_pkg.sv
// Shared types and helpers for the query-profile score sequencer.
// Holds the sequencer state encoding, vector geometry and the chunk-count helper.
package ksw_pkg;

    localparam int LANES  = 16;
    localparam int LANE_W = 8;
    localparam int VEC_W  = LANES * LANE_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Number of 16-byte chunks covering tlen bytes; a partial tail still counts as a chunk.
    function automatic logic [10:0] nchunks(input logic [9:0] tlen);
        logic [10:0] sum_s;
        sum_s = {1'b0, tlen} + 11'd15;
        return sum_s >> 4;
    endfunction

endpackage

// File: rtl/ksw_profile_seq.sv
// Row sequencer: walks 16-byte target chunks through the score datapath and
// writes one 128-bit score vector per chunk into the score buffer.
module ksw_profile_seq
    import ksw_pkg::*;
#(
    parameter int MAX_TLEN = 1000,
    parameter int DP_LAT   = 1,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        row_r,
    input  logic [9:0]        tlen,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [9:0]        dp_t,
    output logic [9:0]        dp_r,
    input  logic [VEC_W-1:0]  dp_s,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [VEC_W-1:0]  wr_data,
    input  logic              wr_ready
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int WAIT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [9:0]        MAX_TLEN_V = 10'(MAX_TLEN);
    localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(DP_LAT - 1);

    state_t              state_r;
    logic [CNT_W-1:0]    chunk_r;
    logic [CNT_W-1:0]    nchunks_r;
    logic [WAIT_W-1:0]   wait_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic [9:0]          dp_t_r;
    logic [9:0]          dp_r_r;
    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [VEC_W-1:0]    wr_data_r;

    logic                start_ok_s;
    logic                last_s;
    logic [CNT_W-1:0]    chunk_nxt_s;

    // Derived control terms; a start coinciding with the done pulse is dropped.
    always_comb begin
        start_ok_s  = 1'b0;
        last_s      = 1'b0;
        chunk_nxt_s = chunk_r + CNT_W'(1);
        if (start && !done_r) begin
            start_ok_s = 1'b1;
        end else begin
            start_ok_s = 1'b0;
        end
        if (chunk_r == (nchunks_r - CNT_W'(1))) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Sequencer FSM with all outputs registered; abort outranks every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            chunk_r   <= '0;
            nchunks_r <= '0;
            wait_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            dp_t_r    <= 10'd0;
            dp_r_r    <= 10'd0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                state_r <= IDLE;
                wr_en_r <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_ok_s) begin
                            if (tlen > MAX_TLEN_V) begin
                                err_r <= 1'b1;
                            end else if (tlen == 10'd0) begin
                                busy_r  <= 1'b1;
                                state_r <= DONE;
                            end else begin
                                busy_r    <= 1'b1;
                                dp_r_r    <= row_r;
                                nchunks_r <= CNT_W'(nchunks(tlen));
                                chunk_r   <= '0;
                                dp_t_r    <= 10'd0;
                                state_r   <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        wait_r  <= WAIT_INIT;
                        state_r <= WAIT;
                    end
                    WAIT: begin
                        if (wait_r == '0) begin
                            wr_data_r <= dp_s;
                            wr_addr_r <= ADDR_W'(chunk_r);
                            wr_en_r   <= 1'b1;
                            state_r   <= WRITE;
                        end else begin
                            wait_r <= wait_r - WAIT_W'(1);
                        end
                    end
                    WRITE: begin
                        if (wr_ready) begin
                            wr_en_r <= 1'b0;
                            if (last_s) begin
                                state_r <= DONE;
                            end else begin
                                chunk_r <= chunk_nxt_s;
                                dp_t_r  <= 10'(chunk_nxt_s) << 4;
                                state_r <= ISSUE;
                            end
                        end
                    end
                    DONE: begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        wr_en_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign dp_t    = dp_t_r;
    assign dp_r    = dp_r_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

endmodule
